// File: rtl/branch_predictor_pkg.sv
// Shared types for the dynamic branch predictor: counter encodings and the core datapath width.
package branch_predictor_pkg;

  localparam int DATA_WIDTH = 32;

  // 2-bit saturating counter states; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    BP_CNT_SNT = 2'b00,
    BP_CNT_WNT = 2'b01,
    BP_CNT_WT  = 2'b10,
    BP_CNT_ST  = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training/feedback signals of the branch predictor.
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
);
  logic              i_clear;
  logic [XLEN-1:0]   i_pc;
  logic              o_pred_taken;
  logic [XLEN-1:0]   o_pred_target;
  logic              i_update;
  logic [XLEN-1:0]   i_update_pc;
  logic              i_update_is_jump;
  logic              i_update_taken;
  logic [XLEN-1:0]   i_update_target;
  logic              i_update_pred_taken;
  logic [XLEN-1:0]   i_update_pred_target;
  logic              o_mispredict;
  logic [XLEN-1:0]   o_redirect_pc;
  logic [PERF_W-1:0] o_mispredict_count;

  modport master (
    output i_clear, i_pc, i_update, i_update_pc, i_update_is_jump, i_update_taken,
           i_update_target, i_update_pred_taken, i_update_pred_target,
    input  o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc, o_mispredict_count
  );

  modport slave (
    input  i_clear, i_pc, i_update, i_update_pc, i_update_is_jump, i_update_taken,
           i_update_target, i_update_pred_taken, i_update_pred_target,
    output o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc, o_mispredict_count
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating up/down counter next-state logic, shared by the training path.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    up,
  output bp_cnt_e cnt_next
);

  always_comb begin
    // NOTE: default first so every path assigns cnt_next and no latch is inferred.
    cnt_next = cnt;
    if (up && cnt != BP_CNT_ST)
      cnt_next = bp_cnt_e'(cnt + 2'd1);
    else if (!up && cnt != BP_CNT_SNT)
      cnt_next = bp_cnt_e'(cnt - 2'd1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB: same-cycle prediction for fetch, training and mispredict feedback from execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         XLEN     = DATA_WIDTH,
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag     [ENTRIES];
  logic [XLEN-1:0]    target  [ENTRIES];
  logic [ENTRIES-1:0] is_jump;
  bp_cnt_e            cnt     [ENTRIES];

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit;
  bp_cnt_e             cnt_next;
  logic                mp;
  logic                unused_pc_bits;

  assign l_idx = bus.i_pc[IDX_BITS+1:2];
  assign l_tag = bus.i_pc[XLEN-1:IDX_BITS+2];
  assign u_idx = bus.i_update_pc[IDX_BITS+1:2];
  assign u_tag = bus.i_update_pc[XLEN-1:IDX_BITS+2];
  assign unused_pc_bits = ^bus.i_pc[1:0];

  // Lookup reads the table as it stands; an update to the same entry shows up next cycle.
  assign l_hit              = valid[l_idx] && (tag[l_idx] == l_tag);
  assign bus.o_pred_taken   = l_hit && (is_jump[l_idx] || cnt[l_idx][1]);
  assign bus.o_pred_target  = l_hit ? target[l_idx] : '0;

  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  bp_sat_counter u_sat (
    .cnt      (cnt[u_idx]),
    .up       (bus.i_update_taken),
    .cnt_next (cnt_next)
  );

  // NOTE: the table is small and must come out of reset invalid, so every entry is reset, not just valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tag[i]     <= '0;
        target[i]  <= '0;
        is_jump[i] <= 1'b0;
        cnt[i]     <= bp_cnt_e'(CNT_INIT);
      end
    end else if (bus.i_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= bp_cnt_e'(CNT_INIT);
      end
    end else if (bus.i_update) begin
      if (bus.i_update_taken) begin
        valid[u_idx]   <= 1'b1;
        tag[u_idx]     <= u_tag;
        target[u_idx]  <= bus.i_update_target;
        is_jump[u_idx] <= bus.i_update_is_jump;
        if (bus.i_update_is_jump)
          cnt[u_idx] <= BP_CNT_ST;
        else if (u_hit)
          cnt[u_idx] <= cnt_next;
        else
          cnt[u_idx] <= BP_CNT_WT;
      end else if (u_hit) begin
        // Untaken branches only train existing entries, never allocate.
        cnt[u_idx] <= cnt_next;
      end
    end
  end

  assign mp = bus.i_update &&
              ((bus.i_update_pred_taken != bus.i_update_taken) ||
               (bus.i_update_taken && (bus.i_update_pred_target != bus.i_update_target)));

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_mispredict       <= 1'b0;
      bus.o_redirect_pc      <= '0;
      bus.o_mispredict_count <= '0;
    end else begin
      bus.o_mispredict <= mp;
      if (mp) begin
        bus.o_redirect_pc <= bus.i_update_taken ? bus.i_update_target
                                                : bus.i_update_pc + XLEN'(4);
        if (bus.o_mispredict_count != '1)
          bus.o_mispredict_count <= bus.o_mispredict_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the RISC-V core; the stateful successor to the combinational branch_unit.
- Fetch stage queries it with the current PC and gets a same-cycle taken/target prediction.
- Execute stage feeds back the resolved branch_unit outcome (o_take, target). The block trains a direct-mapped BHT (2-bit saturating counters) plus a BTB.
- Flags mispredicts one cycle later, with a redirect PC and a saturating mispredict count.

Parameters:
- XLEN, 32, address/data width (matches `DATA_WIDTH`).
- IDX_BITS, 4, log2 of table entries (16 entries); index = PC[IDX_BITS+1:2].
- CNT_INIT, 2'b01, counter reset/clear value (weakly not-taken).
- PERF_W, 16, width of the mispredict counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous invalidate of all entries.
- i_pc  in  XLEN  fetch PC to predict.
- o_pred_taken  out  1  combinational prediction for i_pc.
- o_pred_target  out  XLEN  predicted target; 0 when no BTB hit.
- i_update  in  1  resolved control-flow instruction this cycle.
- i_update_pc  in  XLEN  PC of the resolved instruction.
- i_update_is_jump  in  1  JAL/JALR (BRANCH_JAL_JALR).
- i_update_taken  in  1  actual outcome (branch_unit o_take).
- i_update_target  in  XLEN  actual target.
- i_update_pred_taken  in  1  prediction carried down the pipe.
- i_update_pred_target  in  XLEN  predicted target carried down the pipe.
- o_mispredict  out  1  registered mispredict pulse.
- o_redirect_pc  out  XLEN  correct next PC, valid with o_mispredict.
- o_mispredict_count  out  PERF_W  saturating mispredict total.

Behaviour:

Storage:
- Per entry: valid, tag = PC[XLEN-1:IDX_BITS+2], target[XLEN], is_jump, cnt[1:0].

Reset (async, i_rst_n=0):
- All valid=0, cnt=CNT_INIT, targets/tags=0.
- o_mispredict=0, o_redirect_pc=0, o_mispredict_count=0.
- Reset asserted mid-operation aborts any pending update. No write lands on the deasserting edge.

Lookup (0 latency, purely combinational):
- hit = valid & tag match.
- o_pred_taken = hit & (is_jump | cnt[1]).
- o_pred_target = hit ? target : 0.

Update (registered, takes effect at the edge when i_update=1):
- Taken: write valid=1, tag, target=i_update_target, is_jump.
  - Jump: cnt=2'b11.
  - Conditional branch on a tag hit: cnt saturates up (11 stays 11).
  - Conditional branch on a miss/alias: cnt=2'b10.
- Not taken, tag hit: cnt saturates down (00 stays 00). Entry stays valid.
- Not taken, tag miss: no write (untaken branches are never allocated).

Same-cycle lookup/update to the same index:
- Lookup returns the pre-update value; no bypass.

Mispredict:
- mp = i_update & ((i_update_pred_taken != i_update_taken) | (i_update_taken & i_update_pred_target != i_update_target)).
- Registered: o_mispredict=mp on the next edge, a 1-cycle pulse; deasserts when the next update does not mispredict.
- o_redirect_pc = i_update_taken ? i_update_target : i_update_pc+4 (mod 2^XLEN). Holds its last value when o_mispredict=0.
- o_mispredict_count increments on mp and saturates at all-ones; no wrap.

i_clear:
- Next edge: all valid=0, cnt=CNT_INIT.
- Takes priority over a simultaneous i_update table write.
- Mispredict output/counter still update from the concurrent i_update.

Other rules:
- PC bits [1:0] are ignored.
- No X on outputs after reset.

Decomposition:
- Shared defines header (with `DATA_WIDTH`, BRANCH_* opcodes): add `BP_CNT_SNT` 00, `BP_CNT_WNT` 01, `BP_CNT_WT` 10, `BP_CNT_ST` 11.
- One natural sub-module: bp_sat_counter. It is a 2-bit saturating inc/dec function/module, instantiated per entry or used as the shared next-state logic.

Test Plan:
1. Reset: drive i_rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Lookup of any PC, e.g. 0x00000040, gives o_pred_taken=0, o_pred_target=0.
2. Taken-branch training:
   - Update pc=0x00000040, taken=1, target=0x00000100, pred_taken=0 -> o_mispredict=1 and o_redirect_pc=0x00000100 next cycle; count=1.
   - Lookup 0x40 -> taken=1, target=0x100.
3. Hysteresis:
   - Not-taken update at 0x40 (cnt 10->01) -> lookup predicts not-taken; o_redirect_pc=0x00000044.
   - Two more not-taken -> cnt 00.
   - Then one taken -> cnt 01, still not-taken.
4. Jump plus alias:
   - JAL update pc=0x00000080, target=0x00000200 -> lookup 0x80 is taken.
   - Lookup alias 0x000000C0 (same index when IDX_BITS=4) -> tag miss, not-taken.
5. Clear/same-cycle:
   - i_clear with i_update at 0x40 -> entry invalid afterwards, but o_mispredict still reflects the update.
   - Lookup and update of the same PC in the same cycle -> old prediction returned.
6. Saturation: PERF_W=4, 20 consecutive mispredicts -> o_mispredict_count=4'hF and holds.
